// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit display scan controller:
// segment codes, anode patterns and the BCD conversion state encoding.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } conv_state_t;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] BLANK = 7'b1111111;

  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  localparam logic [3:0] ANODE [0:3] = '{
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Double-dabble correction applied to every BCD nibble before each shift.
  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    return {add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-seven-segment decoder with blanking; anything
// above 9 also decodes to the blank pattern.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] a_to_g
);

  always_comb begin
    a_to_g = BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      a_to_g = SEG_CODE[bcd];
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan and view controller for the four-digit display: arbitrates operand vs.
// result view, converts the chosen values to BCD once per frame, scans digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 2000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] OpA,
  input  logic [3:0] OpB,
  input  logic [7:0] Result,
  input  logic       ResultValid,
  input  logic       Clear,
  output logic [3:0] seg,
  output logic [6:0] a_to_g,
  output logic       isResult,
  output logic       busy
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  // ---------------------------------------------------------------- scan timing
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [1:0]       idx_nx;
  logic             tick;
  logic             frame_end;

  assign tick      = (div == DIV_LAST);
  assign idx_nx    = idx + 2'd1;
  assign frame_end = tick && (idx == 2'd3);

  // idx resets to 3 so the very first tick is a frame boundary selecting digit 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div <= '0;
      idx <= 2'd3;
    end else if (tick) begin
      div <= '0;
      idx <= idx_nx;
    end else begin
      div <= div + 1'b1;
    end
  end

  // ----------------------------------------------------------- view arbitration
  logic [7:0]        res_q;
  logic [HOLD_W-1:0] hold;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_q    <= '0;
      isResult <= 1'b0;
      hold     <= '0;
    end else if (ResultValid) begin
      res_q    <= Result;
      isResult <= 1'b1;
      hold     <= HOLD_INIT;
    end else if (Clear) begin
      isResult <= 1'b0;
      hold     <= '0;
    end else if (frame_end && (hold != '0)) begin
      hold <= hold - 1'b1;
      if (hold == HOLD_W'(1)) begin
        isResult <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------- BCD conversion
  conv_state_t state;
  conv_state_t state_d;
  logic        cv_view;
  logic        pass_b;
  logic        view_q;
  logic [7:0]  cv_a;
  logic [7:0]  cv_b;
  logic [7:0]  bin_sr;
  logic [7:0]  a_bcd;
  logic [11:0] bcd_sr;
  logic [2:0]  iter;
  logic [15:0] frame_q;
  logic [19:0] dd_nx;
  logic        last_iter;

  assign dd_nx     = {dabble_adj(bcd_sr), bin_sr} << 1;
  assign last_iter = (iter == 3'd7);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Operand view loops back through LOAD once to convert OpB after OpA.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (frame_end) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = (cv_view || pass_b) ? COMMIT : LOAD;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cv_view <= 1'b0;
      cv_a    <= '0;
      cv_b    <= '0;
      pass_b  <= 1'b0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      iter    <= '0;
      a_bcd   <= '0;
      frame_q <= '0;
      view_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Inputs are snapshotted here so mid-frame changes cannot leak in.
          if (frame_end) begin
            cv_view <= isResult;
            cv_a    <= isResult ? res_q : {4'h0, OpA};
            cv_b    <= {4'h0, OpB};
            pass_b  <= 1'b0;
          end
        end
        LOAD: begin
          bcd_sr <= '0;
          bin_sr <= pass_b ? cv_b : cv_a;
          iter   <= '0;
          if (pass_b) begin
            a_bcd <= bcd_sr[7:0];
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= dd_nx;
          iter             <= iter + 3'd1;
          if (last_iter && !cv_view) begin
            pass_b <= 1'b1;
          end
        end
        COMMIT: begin
          frame_q <= cv_view ? {4'h0, bcd_sr} : {a_bcd, bcd_sr[7:0]};
          view_q  <= cv_view;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------- display
  logic [15:0] show_q;
  logic        show_view;
  logic [15:0] disp_frame;
  logic        disp_view;
  logic [3:0]  digit;
  logic        lz_sel;
  logic        blank;
  logic        lz0;
  logic        lz1;
  logic        lz2;
  logic [6:0]  dec_out;

  // Digit 0 reads the freshly committed frame; the rest read the frame-long copy.
  assign disp_frame = frame_end ? frame_q : show_q;
  assign disp_view  = frame_end ? view_q  : show_view;
  assign lz0        = (disp_frame[15:12] == 4'h0);
  assign lz1        = lz0 && (disp_frame[11:8] == 4'h0);
  assign lz2        = lz1 && (disp_frame[7:4] == 4'h0);
  assign blank      = disp_view && lz_sel;

  always_comb begin
    digit  = disp_frame[3:0];
    lz_sel = 1'b0;
    case (idx_nx)
      2'd0: begin
        digit  = disp_frame[15:12];
        lz_sel = lz0;
      end
      2'd1: begin
        digit  = disp_frame[11:8];
        lz_sel = lz1;
      end
      2'd2: begin
        digit  = disp_frame[7:4];
        lz_sel = lz2;
      end
      default: begin
        digit  = disp_frame[3:0];
        lz_sel = 1'b0;
      end
    endcase
  end

  seg7_decode u_dec (
    .bcd    (digit),
    .blank  (blank),
    .a_to_g (dec_out)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg       <= 4'hF;
      a_to_g    <= BLANK;
      show_q    <= '0;
      show_view <= 1'b0;
    end else if (tick) begin
      seg    <= ANODE[idx_nx];
      a_to_g <= dec_out;
      if (frame_end) begin
        show_q    <= frame_q;
        show_view <= view_q;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a frame-level reference model
// predicts every output each cycle, with directed frames pinned to literals.
module tb_display_scan_ctrl;

  localparam int SD = 32;
  localparam int HF = 2;
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] C0  = 7'b0000001;
  localparam logic [6:0] C1  = 7'b1001111;
  localparam logic [6:0] C2  = 7'b0010010;
  localparam logic [6:0] C4  = 7'b1001100;
  localparam logic [6:0] C5  = 7'b0100100;
  localparam logic [6:0] C6  = 7'b0100000;
  localparam logic [6:0] C7  = 7'b0001111;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  // ---------------------------------------------------------- clock and reset
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] OpA = '0;
  logic [3:0] OpB = '0;
  logic [7:0] Result = '0;
  logic       ResultValid = 1'b0;
  logic       Clear = 1'b0;
  logic [3:0] seg;
  logic [6:0] a_to_g;
  logic       isResult;
  logic       busy;

  always #5 CLK = ~CLK;

  display_scan_ctrl #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .OpA         (OpA),
    .OpB         (OpB),
    .Result      (Result),
    .ResultValid (ResultValid),
    .Clear       (Clear),
    .seg         (seg),
    .a_to_g      (a_to_g),
    .isResult    (isResult),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // -------------------------------------------------------- reference model
  // Frame codes packed {digit0, digit1, digit2, digit3}, 7 bits each.
  function automatic logic [27:0] frame_codes(input bit is_res, input int r, input int a, input int b);
    int         d [4];
    bit         blk [4];
    logic [27:0] c;
    c = '0;
    if (is_res) begin
      d   = '{0, r / 100, (r / 10) % 10, r % 10};
      blk = '{1'b1, r < 100, r < 10, 1'b0};
    end else begin
      d   = '{a / 10, a % 10, b / 10, b % 10};
      blk = '{1'b0, 1'b0, 1'b0, 1'b0};
    end
    for (int i = 0; i < 4; i++) begin
      c = (c << 7) | {21'd0, (blk[i] ? BLK : SEG_TAB[4'(d[i])])};
    end
    return c;
  endfunction

  int          m_n;
  int          m_hold;
  int          m_res;
  int          busy_left;
  bit          m_isres;
  logic [27:0] exp_q [$];
  logic [27:0] shown;
  logic [3:0]  exp_seg;
  logic [6:0]  exp_ag;

  task automatic model_reset();
    m_n       = 0;
    m_hold    = 0;
    m_res     = 0;
    m_isres   = 1'b0;
    busy_left = 0;
    exp_q.delete();
    exp_q.push_back(frame_codes(1'b0, 0, 0, 0));
    shown   = frame_codes(1'b0, 0, 0, 0);
    exp_seg = 4'hF;
    exp_ag  = BLK;
  endtask

  initial model_reset();

  // A frame converted at one boundary is displayed for the whole next frame.
  always @(posedge CLK) begin
    if (!RST_N) begin
      model_reset();
    end else begin
      bit boundary;
      int d;
      boundary = 1'b0;
      m_n++;
      if (m_n % SD == 0) begin
        d = (m_n / SD - 1) % 4;
        if (d == 0) begin
          boundary = 1'b1;
          exp_q.push_back(frame_codes(m_isres, m_res, int'(OpA), int'(OpB)));
          shown     = exp_q.pop_front();
          busy_left = m_isres ? 10 : 19;
        end
        exp_seg = ~(4'b1000 >> d);
        exp_ag  = 7'(shown >> (21 - 7 * d));
      end
      if (!boundary && busy_left > 0) busy_left--;
      if (ResultValid) begin
        m_res   = int'(Result);
        m_isres = 1'b1;
        m_hold  = HF;
      end else if (Clear) begin
        m_isres = 1'b0;
        m_hold  = 0;
      end else if (boundary && m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_isres = 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------- compare
  always @(negedge CLK) begin
    if (!RST_N) begin
      check("rst_seg", 32'(seg), 32'hF);
      check("rst_a_to_g", 32'(a_to_g), 32'(BLK));
      check("rst_isResult", 32'(isResult), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
    end else begin
      check("seg", 32'(seg), 32'(exp_seg));
      check("a_to_g", 32'(a_to_g), 32'(exp_ag));
      check("isResult", 32'(isResult), 32'(m_isres));
      check("busy", 32'(busy), 32'(busy_left > 0));
    end
  end

  // ------------------------------------------------------------ driver tasks
  task automatic capture(output logic [27:0] fr);
    logic [3:0] prev;
    int         t;
    bit         seen;
    fr   = '0;
    prev = seg;
    t    = 0;
    seen = 1'b0;
    while (t < 8 * SD && !seen) begin
      @(negedge CLK);
      if (seg == 4'b0111 && prev != 4'b0111) seen = 1'b1;
      prev = seg;
      t++;
    end
    check("frame_start_seen", 32'(seen), 32'(1));
    fr[27:21] = a_to_g;
    repeat (SD) @(negedge CLK);
    fr[20:14] = a_to_g;
    repeat (SD) @(negedge CLK);
    fr[13:7] = a_to_g;
    repeat (SD) @(negedge CLK);
    fr[6:0] = a_to_g;
  endtask

  task automatic pulse_result(input logic [7:0] r);
    ResultValid = 1'b1;
    Result      = r;
    @(negedge CLK);
    ResultValid = 1'b0;
    check("isResult_after_valid", 32'(isResult), 32'(1));
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [27:0] fr;
    int          t;
    RST_N = 1'b0;
    OpA   = 4'd12;
    OpB   = 4'd7;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("boot_seg_idle", 32'(seg), 32'hF);
    check("boot_a_to_g_idle", 32'(a_to_g), 32'(BLK));

    capture(fr);
    check("boot_frame_zero", 32'(fr), 32'({C0, C0, C0, C0}));
    capture(fr);
    check("operand_12_7", 32'(fr), 32'({C1, C2, C0, C7}));

    pulse_result(8'd156);
    capture(fr);
    capture(fr);
    check("result_156", 32'(fr), 32'({BLK, C1, C5, C6}));

    pulse_result(8'd0);
    capture(fr);
    capture(fr);
    check("result_0", 32'(fr), 32'({BLK, BLK, BLK, C0}));

    pulse_result(8'd255);
    capture(fr);
    capture(fr);
    check("result_255", 32'(fr), 32'({BLK, C2, C5, C5}));
    check("hold_expired", 32'(isResult), 32'(0));
    capture(fr);
    check("result_255_tail", 32'(fr), 32'({BLK, C2, C5, C5}));
    capture(fr);
    check("operand_back", 32'(fr), 32'({C1, C2, C0, C7}));

    Clear       = 1'b1;
    ResultValid = 1'b1;
    Result      = 8'd42;
    @(negedge CLK);
    Clear       = 1'b0;
    ResultValid = 1'b0;
    check("valid_beats_clear", 32'(isResult), 32'(1));
    capture(fr);
    capture(fr);
    check("result_42", 32'(fr), 32'({BLK, BLK, C4, C2}));

    pulse_result(8'd99);
    repeat (3) @(negedge CLK);
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    check("clear_alone", 32'(isResult), 32'(0));

    repeat (3000) begin
      @(negedge CLK);
      ResultValid = ($urandom_range(0, 149) == 0);
      Result      = 8'($urandom);
      Clear       = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 15) == 0) OpA = 4'($urandom);
      if ($urandom_range(0, 15) == 0) OpB = 4'($urandom);
    end
    @(negedge CLK);
    ResultValid = 1'b0;
    Clear       = 1'b0;

    t = 0;
    while (busy !== 1'b1 && t < 8 * SD) begin
      @(negedge CLK);
      t++;
    end
    check("busy_before_reset", 32'(busy), 32'(1));
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg), 32'hF);
    check("async_rst_a_to_g", 32'(a_to_g), 32'(BLK));
    check("async_rst_isResult", 32'(isResult), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("reboot_seg_idle", 32'(seg), 32'hF);
    capture(fr);
    check("reboot_frame_zero", 32'(fr), 32'({C0, C0, C0, C0}));
    capture(fr);
    repeat (5) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan and view controller for the four-digit seven-segment display in the FourDigitPlus design. It owns the display resource and switches it between two requesters: the operand view (two 4-bit switch operands) and the result view (the 8-bit adder result). It converts the selected values to BCD with a multi-cycle double-dabble sequencer, so frames never tear. It also generates the digit-scan timing and drives the active-low anode and segment outputs.

## Interface
- SCAN_DIV, 100000, CLK cycles per digit slot; must be ≥ 32.
- HOLD_FRAMES, 2000, full 4-digit frames the result view is held before reverting to the operand view.
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- OpA  input  4  operand A, unsigned 0–15.
- OpB  input  4  operand B, unsigned 0–15.
- Result  input  8  adder result, unsigned 0–255; sampled only when ResultValid is high.
- ResultValid  input  1  one-cycle pulse requesting the result view.
- Clear  input  1  one-cycle pulse forcing the operand view.
- seg  output  4  anode enables, active-low, one-hot-low.
- a_to_g  output  7  segments {a..g}, active-low.
- isResult  output  1  current view; 1 = result view.
- busy  output  1  high while the BCD conversion FSM is not IDLE.

## Operation
- **View arbitration**
  - ResultValid: latch Result into res_q, set isResult=1, load hold counter with HOLD_FRAMES.
  - ResultValid while already in result view: relatch and restart the hold.
  - Clear: isResult=0, hold counter = 0.
  - Clear and ResultValid in the same cycle: ResultValid wins.
  - The hold counter decrements once per frame boundary. On the transition to 0, isResult=0.
- **Scan**
  - div counter runs 0..SCAN_DIV-1. tick is asserted when div = SCAN_DIV-1.
  - Digit index 0..3 advances on each tick. The 3→0 wrap is a frame boundary.
  - Anode pattern per index: 0→0111, 1→1011, 2→1101, 3→1110.
- **Conversion FSM**
  - States: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE→LOAD on a frame boundary.
  - Result view: one 8-bit conversion of res_q gives {hundreds, tens, ones}. Thousands is always 0.
  - Operand view: two conversions, OpA then OpB, each zero-extended to 8 bits. Output is {A tens, A ones, B tens, B ones}.
  - LOAD clears the BCD shift register. SHIFT runs exactly 8 iterations; each iteration adds 3 to any nibble ≥ 5, then shifts left 1.
  - After the last conversion, COMMIT writes the 16-bit frame_q and the view_q tag together, then returns to IDLE.
  - Worst case is 19 cycles, always shorter than one digit slot.
- **Blanking**
  - Result view: leading zeros in digits 0–2 are blanked. Digit 3 is always shown.
  - Operand view: no blanking.
  - A blank digit drives a_to_g = 1111111.
- **Segment codes (active-low abcdefg)**
  - 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100
  - 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100
  - Any value > 9 → blank.
- **Reset values**
  - seg = 1111, a_to_g = 1111111, isResult = 0, busy = 0.
  - frame_q = 0, res_q = 0, div = 0, digit index = 3 (so the first tick selects digit 0), FSM = IDLE, hold counter = 0.
  - Reset asserted mid-conversion or mid-hold: everything returns to the reset values immediately, with no partial commit.

## Timing
- seg and a_to_g are registered and update on the cycle after tick. They always change together, with no one-cycle ghosting.
- First display after reset release: seg = 0111 at cycle SCAN_DIV+1.
- isResult changes one cycle after ResultValid or Clear.
- The displayed content changes only at the first frame boundary after the request, plus conversion latency.
- frame_q changes only at COMMIT. COMMIT always falls inside the slot of digit 0, before that slot's next tick.
- Input changes on OpA/OpB mid-frame do not affect the current frame.

## Structure
- Package display_pkg holds:
  - the SEG_CODE[0:9] constants and the BLANK code;
  - the ANODE[0:3] patterns;
  - the conv_state_t enum (IDLE, LOAD, SHIFT, COMMIT).
- Sub-module seg7_decode is combinational: 4-bit BCD plus blank flag in, a_to_g out. It is instantiated once, and the controller registers its output.

## Test plan
1. Reset with SCAN_DIV=32: seg=1111 and a_to_g=1111111 until tick; then seg=0111, a_to_g=0000001 (digit "0").
2. OpA=12, OpB=7, operand view: after the first frame boundary plus 19 cycles, the frame shows 1,2,0,7, i.e. 1001111, 0010010, 0000001, 0001111.
3. ResultValid with Result=156: isResult=1 next cycle. The next frame shows blank,1,5,6. Result=0 shows blank,blank,blank,0. Result=255 shows blank,2,5,5.
4. HOLD_FRAMES=2: after 2 frame boundaries isResult=0, and the following frame shows the operand digits again.
5. Clear and ResultValid in the same cycle: isResult=1 and res_q is latched. A later Clear alone gives isResult=0 next cycle.
6. RST_N asserted while busy=1: all outputs return to reset values immediately. After release, behaviour matches scenario 1.
